// File: rtl/ternary_pkg.sv
// ternary_pkg
// Shared types for the ternary CPU pipeline.
//   trit_t           : one balanced-ternary digit, 2-bit encoded
//   T_ZERO/T_POS/T_NEG : trit encodings
//   pipe_tag_t       : destination-tracking tag carried through EX and MEM
//   PIPE_TAG_BUBBLE  : tag value of an empty pipeline slot
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b10;

  typedef struct packed {
    logic            valid;
    trit_t [2:0]     rd;
    logic            reg_write;
    logic            mem_read;
  } pipe_tag_t;

  localparam pipe_tag_t PIPE_TAG_BUBBLE = '{
    valid:     1'b0,
    rd:        {T_ZERO, T_ZERO, T_ZERO},
    reg_write: 1'b0,
    mem_read:  1'b0
  };

endpackage

// File: rtl/ternary_pipe_tag_reg.sv
// ternary_pipe_tag_reg
// One issue slot's IF/ID, ID/EX and EX/MEM tracking registers.
//   clk, rst_n     : clock, synchronous active-low reset
//   if_valid/instr : fetch-side inputs loaded into ID when not held
//   id_rd/reg_write/mem_read : decode of the current ID instruction
//   hold           : keep ID contents
//   bubble         : insert a bubble into EX instead of the ID tag
//   clear          : redirect; kill ID and EX, MEM still advances
//   id_valid/instr : ID-stage registers
//   ex_tag/mem_tag : EX- and MEM-stage tags
module ternary_pipe_tag_reg
  import ternary_pkg::*;
#(
  parameter int INSTR_TRITS = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_valid,
  input  trit_t [INSTR_TRITS-1:0]      if_instr,
  input  trit_t [2:0]                  id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic                         hold,
  input  logic                         bubble,
  input  logic                         clear,
  output logic                         id_valid,
  output trit_t [INSTR_TRITS-1:0]      id_instr,
  output pipe_tag_t                    ex_tag,
  output pipe_tag_t                    mem_tag
);

  // Decoded ID tag, forced to bubble values for an empty ID slot.
  pipe_tag_t id_tag;

  always_comb begin
    id_tag = PIPE_TAG_BUBBLE;
    if (id_valid) begin
      id_tag.valid     = 1'b1;
      id_tag.rd        = id_rd;
      id_tag.reg_write = id_reg_write;
      id_tag.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= {INSTR_TRITS{T_ZERO}};
      ex_tag   <= PIPE_TAG_BUBBLE;
      mem_tag  <= PIPE_TAG_BUBBLE;
    end else begin
      // Back end never stalls.
      mem_tag <= ex_tag;
      if (clear) begin
        id_valid <= 1'b0;
        ex_tag   <= PIPE_TAG_BUBBLE;
      end else begin
        ex_tag <= bubble ? PIPE_TAG_BUBBLE : id_tag;
        if (!hold) begin
          id_valid <= if_valid;
          id_instr <= if_instr;
        end
      end
    end
  end

endmodule

// File: rtl/ternary_pipe_ctrl_dual.sv
// ternary_pipe_ctrl_dual
// Dual-slot pipeline register and control block. Slot A is older, slot B
// younger; B is never allowed to pass A.
//   clk, rst_n                : clock, synchronous active-low reset
//   if_valid_*/if_instr_*/if_pc : fetch bundle
//   id_rd_*/id_reg_write_*/id_mem_read_* : decode of ID instructions
//   pc_stall, if_id_stall_*, id_ex_flush_*, redirect : hazard/branch control
//   pc_en                     : fetch advance enable (combinational)
//   id_*, ex_*, mem_*         : stage registers / tags fed back to hazard unit
//   stall_cycles              : saturating count of cycles with pc_en=0
module ternary_pipe_ctrl_dual
  import ternary_pkg::*;
#(
  parameter int INSTR_TRITS = 9,
  parameter int PC_TRITS    = 9,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid_a,
  input  logic                      if_valid_b,
  input  trit_t [INSTR_TRITS-1:0]   if_instr_a,
  input  trit_t [INSTR_TRITS-1:0]   if_instr_b,
  input  trit_t [PC_TRITS-1:0]      if_pc,
  input  trit_t [2:0]               id_rd_a,
  input  trit_t [2:0]               id_rd_b,
  input  logic                      id_reg_write_a,
  input  logic                      id_reg_write_b,
  input  logic                      id_mem_read_a,
  input  logic                      id_mem_read_b,
  input  logic                      pc_stall,
  input  logic                      if_id_stall_a,
  input  logic                      if_id_stall_b,
  input  logic                      id_ex_flush_a,
  input  logic                      id_ex_flush_b,
  input  logic                      redirect,
  output logic                      pc_en,
  output logic                      id_valid_a,
  output logic                      id_valid_b,
  output trit_t [INSTR_TRITS-1:0]   id_instr_a,
  output trit_t [INSTR_TRITS-1:0]   id_instr_b,
  output trit_t [PC_TRITS-1:0]      id_pc,
  output logic                      ex_valid_a,
  output logic                      ex_valid_b,
  output trit_t [2:0]               ex_rd_a,
  output trit_t [2:0]               ex_rd_b,
  output logic                      ex_reg_write_a,
  output logic                      ex_reg_write_b,
  output logic                      ex_mem_read_a,
  output logic                      ex_mem_read_b,
  output logic                      mem_valid_a,
  output logic                      mem_valid_b,
  output trit_t [2:0]               mem_rd_a,
  output trit_t [2:0]               mem_rd_b,
  output logic                      mem_reg_write_a,
  output logic                      mem_reg_write_b,
  output logic                      mem_mem_read_a,
  output logic                      mem_mem_read_b,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int NUM_SLOTS = 2;  // index 0 = slot A, 1 = slot B

  logic hold_a, hold_b, bub_a, bub_b;

  // A younger-slot stall is implied by an older-slot stall.
  assign hold_a = if_id_stall_a;
  assign hold_b = if_id_stall_b | if_id_stall_a;
  assign bub_a  = id_ex_flush_a;
  assign bub_b  = id_ex_flush_b | id_ex_flush_a;

  assign pc_en = !(pc_stall | hold_a | hold_b) | redirect;

  logic      [NUM_SLOTS-1:0]                   s_if_valid, s_hold, s_bubble;
  logic      [NUM_SLOTS-1:0]                   s_reg_write, s_mem_read, s_id_valid;
  trit_t     [NUM_SLOTS-1:0][INSTR_TRITS-1:0]  s_if_instr, s_id_instr;
  trit_t     [NUM_SLOTS-1:0][2:0]              s_id_rd;
  pipe_tag_t [NUM_SLOTS-1:0]                   s_ex, s_mem;

  // During a split issue A drains into EX while fetch is frozen; A's ID slot
  // must empty rather than re-capture the same fetch bundle.
  assign s_if_valid  = {if_valid_b, if_valid_a & !hold_b};
  assign s_if_instr  = {if_instr_b, if_instr_a};
  assign s_hold      = {hold_b, hold_a};
  assign s_bubble    = {bub_b, bub_a};
  assign s_id_rd     = {id_rd_b, id_rd_a};
  assign s_reg_write = {id_reg_write_b, id_reg_write_a};
  assign s_mem_read  = {id_mem_read_b, id_mem_read_a};

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    ternary_pipe_tag_reg #(.INSTR_TRITS(INSTR_TRITS)) u_tag (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_valid     (s_if_valid[s]),
      .if_instr     (s_if_instr[s]),
      .id_rd        (s_id_rd[s]),
      .id_reg_write (s_reg_write[s]),
      .id_mem_read  (s_mem_read[s]),
      .hold         (s_hold[s]),
      .bubble       (s_bubble[s]),
      .clear        (redirect),
      .id_valid     (s_id_valid[s]),
      .id_instr     (s_id_instr[s]),
      .ex_tag       (s_ex[s]),
      .mem_tag      (s_mem[s])
    );
  end

  assign id_valid_a      = s_id_valid[0];
  assign id_valid_b      = s_id_valid[1];
  assign id_instr_a      = s_id_instr[0];
  assign id_instr_b      = s_id_instr[1];
  assign ex_valid_a      = s_ex[0].valid;
  assign ex_valid_b      = s_ex[1].valid;
  assign ex_rd_a         = s_ex[0].rd;
  assign ex_rd_b         = s_ex[1].rd;
  assign ex_reg_write_a  = s_ex[0].reg_write;
  assign ex_reg_write_b  = s_ex[1].reg_write;
  assign ex_mem_read_a   = s_ex[0].mem_read;
  assign ex_mem_read_b   = s_ex[1].mem_read;
  assign mem_valid_a     = s_mem[0].valid;
  assign mem_valid_b     = s_mem[1].valid;
  assign mem_rd_a        = s_mem[0].rd;
  assign mem_rd_b        = s_mem[1].rd;
  assign mem_reg_write_a = s_mem[0].reg_write;
  assign mem_reg_write_b = s_mem[1].reg_write;
  assign mem_mem_read_a  = s_mem[0].mem_read;
  assign mem_mem_read_b  = s_mem[1].mem_read;

  // ID PC follows slot A's ID register.
  always_ff @(posedge clk) begin
    if (!rst_n)                  id_pc <= {PC_TRITS{T_ZERO}};
    else if (!redirect && !hold_a) id_pc <= if_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!pc_en && stall_cycles != {CNT_W{1'b1}})
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_ternary_pipe_ctrl_dual.sv
module tb_ternary_pipe_ctrl_dual;
  import ternary_pkg::*;

  localparam int IT = 9;
  localparam int PT = 9;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic if_valid_a, if_valid_b;
  trit_t [IT-1:0] if_instr_a, if_instr_b;
  trit_t [PT-1:0] if_pc;
  trit_t [2:0] id_rd_a, id_rd_b;
  logic id_reg_write_a, id_reg_write_b, id_mem_read_a, id_mem_read_b;
  logic pc_stall, if_id_stall_a, if_id_stall_b, id_ex_flush_a, id_ex_flush_b, redirect;
  logic pc_en, id_valid_a, id_valid_b;
  trit_t [IT-1:0] id_instr_a, id_instr_b;
  trit_t [PT-1:0] id_pc;
  logic ex_valid_a, ex_valid_b, ex_reg_write_a, ex_reg_write_b, ex_mem_read_a, ex_mem_read_b;
  trit_t [2:0] ex_rd_a, ex_rd_b, mem_rd_a, mem_rd_b;
  logic mem_valid_a, mem_valid_b, mem_reg_write_a, mem_reg_write_b, mem_mem_read_a, mem_mem_read_b;
  logic [CW-1:0] stall_cycles;

  ternary_pipe_ctrl_dual #(.INSTR_TRITS(IT), .PC_TRITS(PT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_a(if_valid_a), .if_valid_b(if_valid_b),
    .if_instr_a(if_instr_a), .if_instr_b(if_instr_b), .if_pc(if_pc),
    .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
    .id_reg_write_a(id_reg_write_a), .id_reg_write_b(id_reg_write_b),
    .id_mem_read_a(id_mem_read_a), .id_mem_read_b(id_mem_read_b),
    .pc_stall(pc_stall), .if_id_stall_a(if_id_stall_a), .if_id_stall_b(if_id_stall_b),
    .id_ex_flush_a(id_ex_flush_a), .id_ex_flush_b(id_ex_flush_b), .redirect(redirect),
    .pc_en(pc_en), .id_valid_a(id_valid_a), .id_valid_b(id_valid_b),
    .id_instr_a(id_instr_a), .id_instr_b(id_instr_b), .id_pc(id_pc),
    .ex_valid_a(ex_valid_a), .ex_valid_b(ex_valid_b), .ex_rd_a(ex_rd_a), .ex_rd_b(ex_rd_b),
    .ex_reg_write_a(ex_reg_write_a), .ex_reg_write_b(ex_reg_write_b),
    .ex_mem_read_a(ex_mem_read_a), .ex_mem_read_b(ex_mem_read_b),
    .mem_valid_a(mem_valid_a), .mem_valid_b(mem_valid_b), .mem_rd_a(mem_rd_a), .mem_rd_b(mem_rd_b),
    .mem_reg_write_a(mem_reg_write_a), .mem_reg_write_b(mem_reg_write_b),
    .mem_mem_read_a(mem_mem_read_a), .mem_mem_read_b(mem_mem_read_b),
    .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rd encodings: T_ZERO=00, T_POS=01, T_NEG=10, trit 2 is the MSB pair.
  localparam logic [5:0] RD1 = 6'b00_00_01;  // {Z,Z,P} = 1
  localparam logic [5:0] RD2 = 6'b00_01_10;  // {Z,P,N} = 2
  localparam logic [5:0] RD4 = 6'b00_01_01;  // {Z,P,P} = 4
  localparam logic [5:0] RD5 = 6'b01_10_10;  // {P,N,N} = 5
  localparam logic [17:0] I1A = 18'h05155, I1B = 18'h0A2AA, I2A = 18'h01111;
  localparam logic [17:0] I2B = 18'h02222, I3A = 18'h10101, I3B = 18'h20202;
  localparam logic [17:0] PC1 = 18'h00015;

  initial begin
    rst_n = 0; if_valid_a = 0; if_valid_b = 0;
    if_instr_a = '0; if_instr_b = '0; if_pc = '0;
    id_rd_a = '0; id_rd_b = '0;
    id_reg_write_a = 0; id_reg_write_b = 0; id_mem_read_a = 0; id_mem_read_b = 0;
    pc_stall = 0; if_id_stall_a = 0; if_id_stall_b = 0;
    id_ex_flush_a = 0; id_ex_flush_b = 0; redirect = 0;
    step(); step();
    chk("rst_id_valid", {id_valid_a, id_valid_b}, 2'b00);
    chk("rst_ex_mem_valid", {ex_valid_a, ex_valid_b, mem_valid_a, mem_valid_b}, 4'b0);
    chk("rst_stall_cycles", stall_cycles, 0);

    // Normal advance
    rst_n = 1; if_valid_a = 1; if_valid_b = 1;
    if_instr_a = I1A; if_instr_b = I1B; if_pc = PC1;
    id_rd_a = RD1; id_rd_b = RD2; id_reg_write_a = 1; id_reg_write_b = 1;
    #1 chk("adv_pc_en", pc_en, 1);
    step();
    chk("e1_id_valid", {id_valid_a, id_valid_b}, 2'b11);
    chk("e1_id_instr_a", id_instr_a, I1A);
    chk("e1_id_pc", id_pc, PC1);
    chk("e1_ex_valid", {ex_valid_a, ex_valid_b}, 2'b00);
    step();
    chk("e2_ex_rd_a", ex_rd_a, RD1);
    chk("e2_ex_rd_b", ex_rd_b, RD2);
    chk("e2_ex_flags", {ex_valid_a, ex_valid_b, ex_reg_write_a, ex_reg_write_b, ex_mem_read_a}, 5'b11110);
    step();
    chk("e3_mem_rd", {mem_rd_a, mem_rd_b}, {RD1, RD2});
    chk("e3_mem_flags", {mem_valid_a, mem_valid_b, mem_reg_write_a, mem_reg_write_b}, 4'b1111);
    step();
    chk("e4_stall_cycles", stall_cycles, 0);

    // Hold both slots with bubble
    if_instr_a = I2A; if_instr_b = I2B;
    if_id_stall_a = 1; id_ex_flush_a = 1;
    #1 chk("hold_pc_en", pc_en, 0);
    step();
    chk("hold_id_instr_a", id_instr_a, I1A);
    chk("hold_id_valid", {id_valid_a, id_valid_b}, 2'b11);
    chk("hold_ex_bubble", {ex_valid_a, ex_valid_b, ex_rd_a, ex_rd_b, ex_reg_write_a, ex_reg_write_b}, 16'h0);
    chk("hold_mem_adv", {mem_valid_a, mem_valid_b}, 2'b11);
    chk("hold_stall_cycles", stall_cycles, 1);
    if_id_stall_a = 0; id_ex_flush_a = 0;
    step();
    chk("rel_id_instr", {id_instr_a, id_instr_b}, {I2A, I2B});

    // Split issue
    if_instr_a = I3A; if_instr_b = I3B;
    id_rd_a = RD4; id_rd_b = RD5;
    if_id_stall_b = 1; id_ex_flush_b = 1;
    #1 chk("split_pc_en", pc_en, 0);
    step();
    chk("split_ex_a", {ex_valid_a, ex_rd_a}, {1'b1, RD4});
    chk("split_ex_b", ex_valid_b, 0);
    chk("split_id_valid", {id_valid_a, id_valid_b}, 2'b01);
    chk("split_id_instr_b", id_instr_b, I2B);
    chk("split_stall_cycles", stall_cycles, 2);
    if_id_stall_b = 0; id_ex_flush_b = 0;
    #1 chk("split_rel_pc_en", pc_en, 1);
    step();
    chk("split2_ex_a_bubble", {ex_valid_a, ex_rd_a}, 7'b0);
    chk("split2_ex_b", {ex_valid_b, ex_rd_b}, {1'b1, RD5});
    chk("split2_id_reload", {id_valid_a, id_valid_b, id_instr_a}, {2'b11, I3A});

    // Redirect beats stall
    redirect = 1; pc_stall = 1;
    #1 chk("redir_pc_en", pc_en, 1);
    step();
    chk("redir_id_valid", {id_valid_a, id_valid_b}, 2'b00);
    chk("redir_ex", {ex_valid_a, ex_valid_b, ex_rd_a, ex_rd_b}, 14'h0);
    chk("redir_mem", {mem_valid_a, mem_valid_b, mem_rd_b}, {2'b01, RD5});
    chk("redir_stall_cycles", stall_cycles, 2);

    // Reset mid split-issue
    redirect = 0; pc_stall = 0;
    step();
    if_id_stall_b = 1; id_ex_flush_b = 1;
    step();
    chk("pre_rst_id_valid_b", id_valid_b, 1);
    rst_n = 0;
    step();
    chk("mrst_id", {id_valid_a, id_valid_b, id_instr_b, id_pc}, 38'h0);
    chk("mrst_ex_mem", {ex_valid_a, ex_valid_b, ex_rd_a, mem_valid_a, mem_valid_b, mem_rd_b}, 16'h0);
    chk("mrst_stall_cycles", stall_cycles, 0);
    rst_n = 1; if_id_stall_b = 0; id_ex_flush_b = 0;
    if_valid_a = 0; if_valid_b = 0;
    step();
    chk("mrst_no_b_id", id_valid_b, 0);
    step();
    chk("mrst_no_b_ex", ex_valid_b, 0);

    // Counter saturation
    rst_n = 0;
    step();
    rst_n = 1; pc_stall = 1;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", stall_cycles, 14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold_15", stall_cycles, 15);
    pc_stall = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
